// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Summary  : Builds ALU requests from UART RX bytes and sends the result back
//            over UART TX. Optional checksum byte: ALU_CMD_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int WIDTH          = 32,
    parameter int NUM_OPS        = 8,
    parameter int TIMEOUT_CYCLES = 28000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [7:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_valid_o,
    input  logic             alu_ready_i,
    input  logic [WIDTH-1:0] alu_res_i,
    input  logic             alu_res_valid_i,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(BYTES - 1);
    localparam logic [TMR_W-1:0] c_tmr_last  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       c_err_byte  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RECV_A   = 3'd1,
        S_RECV_B   = 3'd2,
        S_RECV_CK  = 3'd3,
        S_DISPATCH = 3'd4,
        S_WAIT_RES = 3'd5,
        S_SEND     = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic               r_overrun;
`ifdef ALU_CMD_CHECKSUM_EN
    logic [7:0]         r_ck;
`endif

    logic w_recv;
    logic w_last;
    logic w_timeout;
    logic w_op_bad;
    logic w_drop;

    assign w_recv    = (r_state == S_RECV_A) || (r_state == S_RECV_B) || (r_state == S_RECV_CK);
    assign w_last    = (r_cnt == c_last_byte);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign w_timeout = w_recv && !rx_valid_i && (r_timer == c_tmr_last);
    assign w_op_bad  = (32'(r_op) >= 32'(NUM_OPS));
    assign w_drop    = (r_state == S_DISPATCH) || (r_state == S_WAIT_RES) ||
                       (r_state == S_SEND)     || (r_state == S_ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (rx_valid_i) w_next = S_RECV_A;
            S_RECV_A: begin
                if (rx_valid_i && w_last) w_next = S_RECV_B;
                else if (w_timeout)       w_next = S_IDLE;
            end
            S_RECV_B: begin
                if (rx_valid_i && w_last) begin
`ifdef ALU_CMD_CHECKSUM_EN
                    w_next = S_RECV_CK;
`else
                    w_next = w_op_bad ? S_ERR : S_DISPATCH;
`endif
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
`ifdef ALU_CMD_CHECKSUM_EN
            S_RECV_CK: begin
                if (rx_valid_i)
                    w_next = ((r_ck != rx_data_i) || w_op_bad) ? S_ERR : S_DISPATCH;
                else if (w_timeout)
                    w_next = S_IDLE;
            end
`endif
            S_DISPATCH: if (alu_ready_i)             w_next = S_WAIT_RES;
            S_WAIT_RES: if (alu_res_valid_i)         w_next = S_SEND;
            S_SEND:     if (tx_ready_i && w_last)    w_next = S_IDLE;
            S_ERR:      if (tx_ready_i)              w_next = S_IDLE;
            default:                                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_overrun <= 1'b0;
`ifdef ALU_CMD_CHECKSUM_EN
            r_ck      <= '0;
`endif
        end else begin
            if (rx_valid_i && w_drop) r_overrun <= 1'b1;

            if (w_recv) r_timer <= rx_valid_i ? '0 : r_timer + 1'b1;
            else        r_timer <= '0;

            case (r_state)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        r_op  <= rx_data_i;
                        r_cnt <= '0;
`ifdef ALU_CMD_CHECKSUM_EN
                        r_ck  <= rx_data_i;
`endif
                    end
                end
                S_RECV_A, S_RECV_B: begin
                    if (rx_valid_i) begin
                        if (r_state == S_RECV_A) r_a[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                        else                     r_b[{r_cnt, 3'b000} +: 8] <= rx_data_i;
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef ALU_CMD_CHECKSUM_EN
                        r_ck  <= r_ck ^ rx_data_i;
`endif
                    end
                end
                S_WAIT_RES: begin
                    if (alu_res_valid_i) begin
                        r_res <= alu_res_i;
                        r_cnt <= '0;
                    end
                end
                S_SEND: begin
                    // Result drains LSB-first; the low byte is always on the wire.
                    if (tx_ready_i) begin
                        r_res <= r_res >> 8;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_op_o    = r_op;
    assign alu_a_o     = r_a;
    assign alu_b_o     = r_b;
    assign alu_valid_o = (r_state == S_DISPATCH);
    assign tx_valid_o  = (r_state == S_SEND) || (r_state == S_ERR);
    assign tx_data_o   = (r_state == S_SEND) ? r_res[7:0] :
                         (r_state == S_ERR)  ? c_err_byte : 8'h00;
    assign busy_o      = (r_state != S_IDLE);
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Summary  : Self-checking bench for alu_cmd_sequencer with ALU/TX responders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int W   = 32;
    localparam int NB  = W / 8;
    localparam int TMO = 28000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic [7:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_valid;
    logic         alu_ready = 1'b0;
    logic [W-1:0] alu_res = '0;
    logic         alu_res_valid = 1'b0;
    logic         busy;
    logic         overrun;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   tx_q[$];
    int           req_n = 0;
    int           req0 = 0;
    logic [7:0]   req_op = '0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    bit           tx_stall = 1'b0;
    bit           alu_slow = 1'b0;
    bit           ck_bad = 1'b0;
    int           a_dly = 0;
    bit           a_pend = 1'b0;
    logic [W-1:0] a_val = '0;
    logic [7:0]   op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic [W-1:0] exp_res;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(W), .NUM_OPS(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
        .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
        .alu_res_i(alu_res), .alu_res_valid_i(alu_res_valid),
        .busy_o(busy), .overrun_o(overrun)
    );

    function automatic logic [W-1:0] alu_model(input logic [7:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            8'd0:    return a + b;
            8'd1:    return a - b;
            8'd2:    return a & b;
            8'd3:    return a | b;
            8'd4:    return a ^ b;
            8'd5:    return a << b[4:0];
            8'd6:    return a >> b[4:0];
            default: return a * b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART TX side: random backpressure, collects every accepted byte.
    initial forever begin
        @(negedge clk);
        tx_ready = tx_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (tx_valid && tx_ready && rst_n) tx_q.push_back(tx_data);
    end

    // ALU side: random ready, records each request, answers after a delay,
    // and throws stray result strobes while no request is outstanding.
    initial forever begin
        @(negedge clk);
        alu_res_valid = 1'b0;
        if (!rst_n) begin
            a_pend = 1'b0;
        end else if (a_pend) begin
            if (a_dly == 0) begin
                alu_res_valid = 1'b1;
                alu_res = a_val;
                a_pend = 1'b0;
            end else begin
                a_dly--;
            end
        end else if ($urandom_range(0, 7) == 0) begin
            alu_res_valid = 1'b1;
            alu_res = $urandom;
        end
        alu_ready = ($urandom_range(0, 2) != 0);
        if (alu_valid && alu_ready && !a_pend && rst_n) begin
            req_n++;
            req_op = alu_op;
            req_a  = alu_a;
            req_b  = alu_b;
            a_val  = alu_model(alu_op, alu_a, alu_b);
            a_pend = 1'b1;
            a_dly  = alu_slow ? 20 : $urandom_range(0, 3);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // long_idx: byte index preceded by an idle gap that lands exactly on the expiry cycle.
    task automatic send_pkt(input logic [7:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int long_idx);
        logic [7:0] bytes[$];
        bytes.push_back(o);
        for (int i = 0; i < NB; i++) bytes.push_back(a[8*i +: 8]);
        for (int i = 0; i < NB; i++) bytes.push_back(b[8*i +: 8]);
`ifdef ALU_CMD_CHECKSUM_EN
        begin
            logic [7:0] ck = 8'h00;
            foreach (bytes[i]) ck = ck ^ bytes[i];
            bytes.push_back(ck_bad ? (ck ^ 8'h01) : ck);
        end
`endif
        req0 = req_n;
        tx_q.delete();
        foreach (bytes[i]) begin
            if (i == long_idx) repeat (TMO - 2) @(posedge clk);
            else               repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(bytes[i]);
        end
    endtask

    task automatic check_pkt(input logic [7:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit err = (o >= 8'd8) || ck_bad;
        int n = err ? 1 : NB;
        int t = 0;
        logic [7:0] got;
        exp_res = alu_model(o, a, b);
        while ((tx_q.size() < n || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("tx_count", tx_q.size(), n);
        check("busy_after", busy, 1'b0);
        for (int i = 0; i < n; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            check("tx_byte", got, err ? 8'hEE : exp_res[8*i +: 8]);
        end
        check("alu_reqs", req_n - req0, err ? 0 : 1);
        if (!err) begin
            check("alu_op", req_op, o);
            check("alu_a", req_a, a);
            check("alu_b", req_b, b);
        end
    endtask

    task automatic wait_tx_valid();
        int t = 0;
        while (!tx_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("tx_valid_wait", tx_valid, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_alu_valid"}, alu_valid, 1'b0);
        check({tag, "_alu_op"}, alu_op, 8'h00);
        check({tag, "_alu_a"}, alu_a, '0);
        check({tag, "_alu_b"}, alu_b, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Directed add: 5 + 3 -> 08 00 00 00
        send_pkt(8'd0, 32'd5, 32'd3, -1);
        check_pkt(8'd0, 32'd5, 32'd3);

        // Invalid opcode -> single 0xEE, no ALU request
        opa = $urandom; opb = $urandom;
        send_pkt(8'd9, opa, opb, -1);
        check_pkt(8'd9, opa, opb);

        for (int k = 0; k < 12; k++) begin
            op  = 8'($urandom_range(0, 10));
            opa = $urandom;
            opb = $urandom;
            send_pkt(op, opa, opb, -1);
            check_pkt(op, opa, opb);
        end

        // TX stalled for 10 cycles: first byte must hold
        tx_stall = 1'b1;
        opa = $urandom; opb = $urandom;
        send_pkt(8'd2, opa, opb, -1);
        wait_tx_valid();
        exp_res = alu_model(8'd2, opa, opb);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", tx_valid, 1'b1);
            check("stall_data", tx_data, exp_res[7:0]);
        end
        tx_stall = 1'b0;
        check_pkt(8'd2, opa, opb);

        // Partial packet then idle: dropped silently
        req0 = req_n;
        tx_q.delete();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        repeat (TMO) @(posedge clk);
        #1;
        check("timeout_tx", tx_q.size(), 0);
        check("timeout_busy", busy, 1'b0);
        check("timeout_reqs", req_n - req0, 0);
        send_pkt(8'd0, 32'd5, 32'd3, -1);
        check_pkt(8'd0, 32'd5, 32'd3);

        // Byte arriving exactly on the expiry cycle is kept
        opa = $urandom; opb = $urandom;
        send_pkt(8'd4, opa, opb, 3);
        check_pkt(8'd4, opa, opb);

        // Byte during WAIT_RES -> overrun, result intact
        check("overrun_pre", overrun, 1'b0);
        alu_slow = 1'b1;
        opa = $urandom; opb = $urandom;
        send_pkt(8'd1, opa, opb, -1);
        for (int t = 0; t < 400 && req_n == req0; t++) @(negedge clk);
        check("slow_req_seen", req_n - req0, 1);
        send_byte(8'h5A);
        check("overrun_set", overrun, 1'b1);
        alu_slow = 1'b0;
        check_pkt(8'd1, opa, opb);
        check("overrun_sticky", overrun, 1'b1);

        // Reset asserted mid-SEND
        tx_stall = 1'b1;
        opa = $urandom; opb = $urandom;
        send_pkt(8'd3, opa, opb, -1);
        wait_tx_valid();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tx_stall = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_tx", tx_q.size(), 0);
        check("midrst_idle", busy, 1'b0);

        opa = $urandom; opb = $urandom;
        send_pkt(8'd7, opa, opb, -1);
        check_pkt(8'd7, opa, opb);

`ifdef ALU_CMD_CHECKSUM_EN
        ck_bad = 1'b0;
        send_pkt(8'd0, 32'd5, 32'd3, -1);
        check_pkt(8'd0, 32'd5, 32'd3);
        ck_bad = 1'b1;
        send_pkt(8'd0, 32'd5, 32'd3, -1);
        check_pkt(8'd0, 32'd5, 32'd3);
        ck_bad = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
